mac_array_seq: RTL

- Sequencer for the weight-stationary (WS) and output-stationary (OS) systolic MAC array.
- Per job, generates the array's instruction stream and the read addresses for the local input SRAM that feeds the array's west inputs.
- Counts the valid result beats leaving the array's south edge and reports completion.
- Sits between the core-level host FSM (start/mode/length) and the array plus its input SRAM.

---
 rtl/mac_array_seq_if.sv | 33 +++
 rtl/mac_array_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mac_array_seq_if.sv
// Host/array-facing signal bundle for the systolic MAC array sequencer.
// start is a one-cycle request taken only in IDLE; stall is the sole back-pressure and gates issue.
interface mac_array_seq_if #(
  parameter int col        = 8,
  parameter int len_bw     = 10,
  parameter int addr_bw    = 11,
  parameter int inst_width = 4
);
  logic                  start;
  logic                  mode;
  logic [len_bw-1:0]     num_vec;
  logic [addr_bw-1:0]    w_base;
  logic [addr_bw-1:0]    x_base;
  logic                  stall;
  logic [col-1:0]        array_valid;
  logic                  mem_rd_en;
  logic [addr_bw-1:0]    mem_rd_addr;
  logic [inst_width-1:0] inst_w;
  logic                  busy;
  logic                  done;
  logic                  timeout;
  logic [2:0]            dbg_state;

  modport master (
    output start, mode, num_vec, w_base, x_base, stall, array_valid,
    input  mem_rd_en, mem_rd_addr, inst_w, busy, done, timeout, dbg_state
  );

  modport slave (
    input  start, mode, num_vec, w_base, x_base, stall, array_valid,
    output mem_rd_en, mem_rd_addr, inst_w, busy, done, timeout, dbg_state
  );
endinterface

// File: rtl/mac_array_seq.sv
// Job sequencer for the WS/OS systolic MAC array: issues SRAM reads plus the
// matching instruction stream, counts south-edge result beats and signals completion.
module mac_array_seq #(
  parameter int row        = 8,
  parameter int col        = 8,
  parameter int inst_width = 4,
  parameter int len_bw     = 10,
  parameter int addr_bw    = 11,
  parameter int drain_max  = 64
) (
  input  logic           clk,
  input  logic           reset,
  mac_array_seq_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_KLOAD, S_EXEC, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  localparam int dcw = $clog2(drain_max + 1);
  localparam logic [inst_width-1:0] I_KLOAD = inst_width'(1);
  localparam logic [inst_width-1:0] I_WS    = inst_width'(2);
  localparam logic [inst_width-1:0] I_OS    = inst_width'(4);
  localparam logic [inst_width-1:0] I_FLUSH = inst_width'(8);

  state_t                r_state;
  logic                  r_mode;
  logic [len_bw-1:0]     r_num;
  logic [len_bw-1:0]     r_idx;
  logic [len_bw-1:0]     r_beats;
  logic [addr_bw-1:0]    r_wbase;
  logic [addr_bw-1:0]    r_xbase;
  logic [dcw-1:0]        r_dcnt;
  logic [inst_width-1:0] r_inst;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_timeout;

  logic                  w_issue_state;
  logic                  w_issue;
  logic                  w_rd_en;
  logic                  w_beat;
  logic                  w_last_issue;
  logic                  w_drain_ok;
  logic [len_bw-1:0]     w_last_idx;
  logic [len_bw-1:0]     w_beats_nxt;
  logic [len_bw-1:0]     w_expect;
  logic [addr_bw-1:0]    w_base_sel;
  logic [addr_bw-1:0]    w_addr;
  logic [inst_width-1:0] w_inst;

  always_comb begin
    w_issue_state = (r_state == S_KLOAD) || (r_state == S_EXEC) || (r_state == S_FLUSH);
    w_issue       = w_issue_state && !bus.stall;
    w_rd_en       = w_issue && (r_state != S_FLUSH);
    w_base_sel    = (r_state == S_KLOAD) ? r_wbase : r_xbase;
    w_addr        = w_rd_en ? (w_base_sel + addr_bw'(r_idx)) : '0;
    w_inst        = '0;
    w_last_idx    = '0;
    case (r_state)
      S_KLOAD: begin
        w_inst     = I_KLOAD;
        w_last_idx = len_bw'(col - 1);
      end
      S_EXEC: begin
        w_inst     = r_mode ? I_OS : I_WS;
        w_last_idx = r_num - 1'b1;
      end
      S_FLUSH: begin
        w_inst     = I_FLUSH;
        w_last_idx = len_bw'(row - 1);
      end
      default: ;
    endcase
    if (!w_issue) w_inst = '0;
    w_last_issue = (r_idx == w_last_idx);
    // Beats landing while instructions are still issuing count toward the job too.
    w_beat       = bus.array_valid[col-1] && (w_issue_state || (r_state == S_DRAIN));
    w_beats_nxt  = (w_beat && (r_beats != '1)) ? r_beats + 1'b1 : r_beats;
    w_expect     = r_mode ? len_bw'(row) : r_num;
    w_drain_ok   = (w_beats_nxt >= w_expect);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_num     <= '0;
      r_idx     <= '0;
      r_beats   <= '0;
      r_wbase   <= '0;
      r_xbase   <= '0;
      r_dcnt    <= '0;
      r_inst    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_inst  <= w_inst;
      r_beats <= w_beats_nxt;
      r_done  <= 1'b0;
      if (r_state != S_DRAIN) r_dcnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode    <= bus.mode;
            r_num     <= bus.num_vec;
            r_wbase   <= bus.w_base;
            r_xbase   <= bus.x_base;
            r_idx     <= '0;
            r_beats   <= '0;
            r_timeout <= 1'b0;
            if (bus.num_vec == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= bus.mode ? S_EXEC : S_KLOAD;
            end
          end
        end
        S_KLOAD, S_EXEC, S_FLUSH: begin
          if (w_issue) begin
            if (w_last_issue) begin
              r_idx <= '0;
              if (r_state == S_KLOAD)      r_state <= S_EXEC;
              else if (r_state == S_FLUSH) r_state <= S_DRAIN;
              else                         r_state <= r_mode ? S_FLUSH : S_DRAIN;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_drain_ok) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_dcnt == dcw'(drain_max - 1)) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en   = w_rd_en;
  assign bus.mem_rd_addr = w_addr;
  assign bus.inst_w      = r_inst;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.dbg_state   = r_state;
endmodule
